// File: rtl/barrier_spawn_gen.sv
// barrier_spawn_gen: batches of NUM_BARRIERS random barriers (X,Y,Height,Length)
// drawn by bounded rejection sampling from a free-running Galois LFSR.
// Ports: Clk, Reset (async, high); Seed/Seed_Load reseed the LFSR;
// Req starts a batch and Busy is high while one runs. Out_Valid/Out_Ack
// handshake each barrier, tagged with Index; Done pulses after the last ack.
module barrier_spawn_gen #(
  parameter int unsigned NUM_BARRIERS = 4,
  parameter int unsigned COORD_W = 10,
  parameter int unsigned LFSR_W = 24,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 24'hE10000,
  parameter logic [LFSR_W-1:0] LFSR_INIT = 24'hACE1B5,
  parameter int unsigned X_MIN = 100,
  parameter int unsigned X_SPAN = 400,
  parameter int unsigned Y_MIN = 45,
  parameter int unsigned Y_SPAN = 360,
  parameter int unsigned H_MIN = 5,
  parameter int unsigned H_SPAN = 30,
  parameter int unsigned L_MIN = 5,
  parameter int unsigned L_SPAN = 50,
  parameter int unsigned MAX_TRIES = 3,
  localparam int unsigned IDX_W =
    (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [LFSR_W-1:0]  Seed,
  input  logic               Seed_Load,
  input  logic               Req,
  output logic               Busy,
  output logic               Out_Valid,
  input  logic               Out_Ack,
  output logic [IDX_W-1:0]   Index,
  output logic [COORD_W-1:0] X,
  output logic [COORD_W-1:0] Y,
  output logic [COORD_W-1:0] Height,
  output logic [COORD_W-1:0] Length,
  output logic               Done
);

  localparam int unsigned TRY_W =
    (MAX_TRIES > 0) ? $clog2(MAX_TRIES + 1) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] GEN_X = 3'd1;
  localparam logic [2:0] GEN_Y = 3'd2;
  localparam logic [2:0] GEN_H = 3'd3;
  localparam logic [2:0] GEN_L = 3'd4;
  localparam logic [2:0] EMIT  = 3'd5;

  // Power-of-two masks just covering each span, so a
  // rejected candidate minus SPAN is always in range.
  localparam logic [COORD_W-1:0] X_MASK =
    COORD_W'((1 << $clog2(X_SPAN)) - 1);
  localparam logic [COORD_W-1:0] Y_MASK =
    COORD_W'((1 << $clog2(Y_SPAN)) - 1);
  localparam logic [COORD_W-1:0] H_MASK =
    COORD_W'((1 << $clog2(H_SPAN)) - 1);
  localparam logic [COORD_W-1:0] L_MASK =
    COORD_W'((1 << $clog2(L_SPAN)) - 1);

  logic [2:0]         state;
  logic [LFSR_W-1:0]  lfsr;
  logic [LFSR_W-1:0]  lfsr_step;
  logic [TRY_W-1:0]   try_cnt;
  logic [COORD_W-1:0] span_c;
  logic [COORD_W-1:0] min_c;
  logic [COORD_W-1:0] mask_c;
  logic [COORD_W-1:0] cand;
  logic [COORD_W-1:0] field_c;
  logic               take;
  logic               give_up;
  logic               advance;
  logic               last_idx;

  assign lfsr_step = {1'b0, lfsr[LFSR_W-1:1]}
                   ^ (lfsr[0] ? LFSR_TAPS : '0);

  always_comb begin
    span_c = '0;
    min_c  = '0;
    mask_c = '0;
    case (state)
      GEN_X: begin
        span_c = COORD_W'(X_SPAN);
        min_c  = COORD_W'(X_MIN);
        mask_c = X_MASK;
      end
      GEN_Y: begin
        span_c = COORD_W'(Y_SPAN);
        min_c  = COORD_W'(Y_MIN);
        mask_c = Y_MASK;
      end
      GEN_H: begin
        span_c = COORD_W'(H_SPAN);
        min_c  = COORD_W'(H_MIN);
        mask_c = H_MASK;
      end
      GEN_L: begin
        span_c = COORD_W'(L_SPAN);
        min_c  = COORD_W'(L_MIN);
        mask_c = L_MASK;
      end
      default: ;
    endcase
  end

  assign cand     = lfsr[COORD_W-1:0] & mask_c;
  assign take     = cand < span_c;
  assign give_up  = try_cnt == TRY_W'(MAX_TRIES);
  assign advance  = take | give_up;
  assign field_c  = take ? (min_c + cand)
                         : (min_c + (cand - span_c));
  assign last_idx = Index == IDX_W'(NUM_BARRIERS - 1);
  assign Busy     = state != IDLE;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lfsr      <= LFSR_INIT;
      state     <= IDLE;
      try_cnt   <= '0;
      Index     <= '0;
      X         <= '0;
      Y         <= '0;
      Height    <= '0;
      Length    <= '0;
      Out_Valid <= 1'b0;
      Done      <= 1'b0;
    end else begin
      if (Seed_Load)
        lfsr <= (Seed == '0) ? LFSR_W'(1) : Seed;
      else
        lfsr <= lfsr_step;
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Req) begin
            state   <= GEN_X;
            Index   <= '0;
            try_cnt <= '0;
          end
        end
        GEN_X, GEN_Y, GEN_H, GEN_L: begin
          if (advance) begin
            try_cnt <= '0;
            state   <= state + 3'd1;
            if (state == GEN_L)
              Out_Valid <= 1'b1;
          end else begin
            try_cnt <= try_cnt + TRY_W'(1);
          end
          if (advance) begin
            case (state)
              GEN_X:   X      <= field_c;
              GEN_Y:   Y      <= field_c;
              GEN_H:   Height <= field_c;
              default: Length <= field_c;
            endcase
          end
        end
        EMIT: begin
          if (Out_Ack) begin
            Out_Valid <= 1'b0;
            if (last_idx) begin
              state <= IDLE;
              Done  <= 1'b1;
            end else begin
              Index <= Index + IDX_W'(1);
              state <= GEN_X;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_barrier_spawn_gen.sv
// tb_barrier_spawn_gen: scoreboard bench for barrier_spawn_gen.
// Predicted barriers are queued at Req; a negedge monitor checks handshakes.
module tb_barrier_spawn_gen;

  typedef struct packed {
    logic [1:0] idx;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] h;
    logic [9:0] l;
  } bar_t;

  logic        Clk;
  logic        Reset;
  logic [23:0] Seed;
  logic        Seed_Load;
  logic        Req;
  logic        Busy;
  logic        Out_Valid;
  logic        Out_Ack;
  logic [1:0]  Index;
  logic [9:0]  X, Y, Height, Length;
  logic        Done;

  logic [23:0] Seed2;
  logic        Seed_Load2;
  logic        Req2;
  logic        Busy2;
  logic        Out_Valid2;
  logic        Out_Ack2;
  logic [1:0]  Index2;
  logic [9:0]  X2, Y2, Height2, Length2;
  logic        Done2;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  bar_t sb[$];
  bar_t seen[$];
  bar_t pred[4];
  int   pred_g0;
  bit   pred_hforced0;

  barrier_spawn_gen u_dut (
    .Clk(Clk), .Reset(Reset), .Seed(Seed),
    .Seed_Load(Seed_Load), .Req(Req), .Busy(Busy),
    .Out_Valid(Out_Valid), .Out_Ack(Out_Ack),
    .Index(Index), .X(X), .Y(Y), .Height(Height),
    .Length(Length), .Done(Done)
  );

  barrier_spawn_gen #(.H_SPAN(33)) u_dut2 (
    .Clk(Clk), .Reset(Reset), .Seed(Seed2),
    .Seed_Load(Seed_Load2), .Req(Req2), .Busy(Busy2),
    .Out_Valid(Out_Valid2), .Out_Ack(Out_Ack2),
    .Index(Index2), .X(X2), .Y(Y2), .Height(Height2),
    .Length(Length2), .Done(Done2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] lstep(input logic [23:0] v);
    return {1'b0, v[23:1]} ^ (v[0] ? 24'hE10000 : 24'h0);
  endfunction

  task automatic draw(inout logic [23:0] v,
                      input int mn, input int span,
                      input int mask, output int val,
                      output int draws, output bit forced);
    int tries;
    int c;
    tries = 0;
    draws = 0;
    forced = 0;
    val = 0;
    for (int k = 0; k < 100; k++) begin
      c = int'(v[9:0]) & mask;
      v = lstep(v);
      draws++;
      if (c < span) begin
        val = mn + c;
        break;
      end else if (tries < 3) begin
        tries++;
      end else begin
        val = mn + c - span;
        forced = 1;
        break;
      end
    end
  endtask

  // Seed and Req share the start edge; Out_Ack is high except
  // that barrier 0 may be held in EMIT for stall0 extra edges.
  task automatic predict(input logic [23:0] seed,
                         input int hspan, input int hmask,
                         input int stall0);
    logic [23:0] v;
    int val, dr, g;
    bit fc;
    v = (seed == 24'd0) ? 24'd1 : seed;
    for (int b = 0; b < 4; b++) begin
      g = 0;
      pred[b].idx = 2'(b);
      draw(v, 100, 400, 511, val, dr, fc);
      pred[b].x = 10'(val);
      g += dr;
      draw(v, 45, 360, 511, val, dr, fc);
      pred[b].y = 10'(val);
      g += dr;
      draw(v, 5, hspan, hmask, val, dr, fc);
      pred[b].h = 10'(val);
      g += dr;
      if (b == 0) pred_hforced0 = fc;
      draw(v, 5, 50, 63, val, dr, fc);
      pred[b].l = 10'(val);
      g += dr;
      if (b == 0) pred_g0 = g;
      for (int e = 0; e < 1 + ((b == 0) ? stall0 : 0); e++)
        v = lstep(v);
    end
  endtask

  always @(negedge Clk) begin
    bar_t got;
    bar_t exp;
    if (!Reset && Done) done_cnt++;
    if (!Reset && Out_Valid && Out_Ack) begin
      got = {Index, X, Y, Height, Length};
      seen.push_back(got);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got %h want none", got);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL sb_barrier got %h want %h", got, exp);
        end
      end
      checks++;
      if (!(X >= 100 && X <= 499 && Y >= 45 && Y <= 404 &&
            Height >= 5 && Height <= 34 &&
            Length >= 5 && Length <= 54)) begin
        errors++;
        $display("FAIL range got %0d %0d %0d %0d want in range",
                 X, Y, Height, Length);
      end
    end
  end

  task automatic run_batch(input logic [23:0] seed,
                           input bit mid_req);
    int n;
    predict(seed, 30, 31, 0);
    for (int b = 0; b < 4; b++) sb.push_back(pred[b]);
    Seed = seed;
    Seed_Load = 1'b1;
    Req = 1'b1;
    @(posedge Clk);
    #1;
    Seed_Load = 1'b0;
    Req = 1'b0;
    chk("busy_after_req", 64'(Busy), 64'd1);
    chk("lfsr_seeded", 64'(u_dut.lfsr),
        64'((seed == 24'd0) ? 24'd1 : seed));
    n = 0;
    while (n < 300) begin
      @(negedge Clk);
      n++;
      if (mid_req && n == 8) Req = 1'b1;
      if (n == 9) Req = 1'b0;
      if (Done) break;
    end
    chk("done_seen", 64'(n < 300), 64'd1);
    chk("busy_at_done", 64'(Busy), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    sb.delete();
    @(posedge Clk);
    #1;
    chk("done_one_cycle", 64'(Done), 64'd0);
  endtask

  initial begin
    bar_t cap;
    bar_t first[$];
    logic [23:0] sd;
    int n, dc0;
    bit ok, found;

    Reset = 1'b1;
    Seed = '0;
    Seed_Load = 1'b0;
    Req = 1'b0;
    Out_Ack = 1'b1;
    Seed2 = '0;
    Seed_Load2 = 1'b0;
    Req2 = 1'b0;
    Out_Ack2 = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    chk("reset_outputs",
        64'({Busy, Out_Valid, Done, Index, X, Y, Height, Length}),
        64'd0);
    repeat (7) @(posedge Clk);
    #1;
    chk("idle_busy", 64'(Busy), 64'd0);

    run_batch(24'h00BEEF, 1'b0);

    dc0 = done_cnt;
    seen.delete();
    run_batch(24'h5A5A5A, 1'b1);
    chk("batch_hs_count", 64'(seen.size()), 64'd4);
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (Busy || Out_Valid) ok = 0;
    end
    chk("no_second_batch", 64'(ok), 64'd1);
    chk("one_done_pulse", 64'(done_cnt - dc0), 64'd1);

    seen.delete();
    run_batch(24'h123456, 1'b0);
    first = seen;
    seen.delete();
    run_batch(24'h123456, 1'b0);
    chk("reseed_len", 64'(seen.size()), 64'd4);
    ok = (first.size() == 4) && (seen.size() == 4);
    for (int i = 0; i < 4 && ok; i++)
      if (first[i] !== seen[i]) ok = 0;
    chk("reseed_repeat", 64'(ok), 64'd1);

    run_batch(24'h000000, 1'b0);

    predict(24'hC0FFEE, 30, 31, 20);
    for (int b = 0; b < 4; b++) sb.push_back(pred[b]);
    Out_Ack = 1'b0;
    Seed = 24'hC0FFEE;
    Seed_Load = 1'b1;
    Req = 1'b1;
    @(posedge Clk);
    #1;
    Seed_Load = 1'b0;
    Req = 1'b0;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!Out_Valid && n < 100);
    chk("bp_valid_seen", 64'(Out_Valid), 64'd1);
    cap = {Index, X, Y, Height, Length};
    ok = 1;
    repeat (20) begin
      @(posedge Clk);
      #1;
      if (!Out_Valid || {Index, X, Y, Height, Length} !== cap)
        ok = 0;
    end
    chk("bp_stable", 64'(ok), 64'd1);
    Out_Ack = 1'b1;
    @(posedge Clk);
    #1;
    chk("bp_valid_drop", 64'(Out_Valid), 64'd0);
    n = 0;
    while (!Done && n < 300) begin
      @(negedge Clk);
      n++;
    end
    chk("bp_done", 64'(Done), 64'd1);
    chk("bp_drained", 64'(sb.size()), 64'd0);
    sb.delete();
    @(posedge Clk);
    #1;

    found = 0;
    sd = 24'd0;
    for (int s = 1; s < 20000 && !found; s++) begin
      sd = 24'(s * 40503);
      predict(sd, 33, 63, 0);
      if (pred_hforced0) found = 1;
    end
    chk("force_seed_found", 64'(found), 64'd1);
    Out_Ack2 = 1'b0;
    Seed2 = sd;
    Seed_Load2 = 1'b1;
    Req2 = 1'b1;
    @(posedge Clk);
    #1;
    Seed_Load2 = 1'b0;
    Req2 = 1'b0;
    n = 0;
    do begin
      @(posedge Clk);
      #1;
      n++;
    end while (!Out_Valid2 && n < 100);
    chk("force_latency", 64'(n), 64'(pred_g0));
    chk("force_height", 64'(Height2), 64'(pred[0].h));
    chk("force_fields", 64'({X2, Y2, Length2}),
        64'({pred[0].x, pred[0].y, pred[0].l}));
    Out_Ack2 = 1'b1;

    for (int i = 0; i < 2000; i++)
      run_batch(24'($urandom), 1'b0);

    Seed = 24'h0F0F0F;
    Seed_Load = 1'b1;
    Req = 1'b1;
    @(posedge Clk);
    #1;
    Seed_Load = 1'b0;
    Req = 1'b0;
    n = 0;
    while (u_dut.state != 3'd2 && n < 20) begin
      @(posedge Clk);
      #1;
      n++;
    end
    chk("abort_in_gen_y", 64'(u_dut.state), 64'd2);
    dc0 = done_cnt;
    Reset = 1'b1;
    #1;
    chk("abort_outputs",
        64'({Busy, Out_Valid, Done, Index, X, Y, Height, Length}),
        64'd0);
    chk("abort_lfsr", 64'(u_dut.lfsr), 64'hACE1B5);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (Busy || Out_Valid) ok = 0;
    end
    chk("abort_stays_idle", 64'(ok), 64'd1);
    chk("abort_no_done", 64'(done_cnt - dc0), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
